// File: rtl/packed_array_serializer.sv
// Serializes the first `size` elements of a packed vector onto a valid/ready
// stream, tagging each beat with its index, a last flag and a running sum.
module packed_array_serializer #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(NUM + 1),
  parameter int SUM_W = WIDTH + $clog2(NUM) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]     in_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [SUM_W-1:0]     out_sum
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_p0, state_n;
  logic [NUM*WIDTH-1:0] data_p0, data_n;
  logic [CNT_W-1:0]     size_p0, size_n;
  logic [CNT_W-1:0]     idx_p0, idx_n;
  logic [SUM_W-1:0]     acc_p0, acc_n;

  logic                 send;
  logic                 last;
  logic [WIDTH-1:0]     cur;
  logic [CNT_W-1:0]     req_size;

  function automatic logic [CNT_W-1:0] clamp_size(input logic [CNT_W-1:0] s);
    if (s > CNT_W'(NUM)) return CNT_W'(NUM);
    return s;
  endfunction

  // Compare-based select keeps the index in range even when idx == NUM.
  function automatic logic [WIDTH-1:0] elem(input logic [NUM*WIDTH-1:0] d,
                                            input logic [CNT_W-1:0] i);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM; k++) begin
      if (i == CNT_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign send     = (state_p0 == SEND);
  assign req_size = clamp_size(in_size);
  assign cur      = elem(data_p0, idx_p0);
  assign last     = (idx_p0 == size_p0 - CNT_W'(1));

  assign in_ready  = !send;
  assign out_valid = send;
  assign out_data  = send ? cur : '0;
  assign out_idx   = send ? idx_p0 : '0;
  assign out_last  = send && last;
  assign out_sum   = send ? acc_p0 + SUM_W'(cur) : '0;

  always_comb begin
    state_n = state_p0;
    data_n  = data_p0;
    size_n  = size_p0;
    idx_n   = idx_p0;
    acc_n   = acc_p0;
    case (state_p0)
      IDLE: begin
        if (in_valid) begin
          data_n = in_data;
          size_n = req_size;
          idx_n  = '0;
          acc_n  = '0;
          if (req_size != '0) state_n = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          acc_n = acc_p0 + SUM_W'(cur);
          idx_n = idx_p0 + CNT_W'(1);
          if (last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: latched vector and beat bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      data_p0  <= '0;
      size_p0  <= '0;
      idx_p0   <= '0;
      acc_p0   <= '0;
    end else begin
      state_p0 <= state_n;
      data_p0  <= data_n;
      size_p0  <= size_n;
      idx_p0   <= idx_n;
      acc_p0   <= acc_n;
    end
  end

endmodule
